// File: rtl/alarm_clock_pkg.sv
// Shared types for the alarm clock controller: FSM states, mode codes and time-field widths.
package alarm_clock_pkg;

    localparam int unsigned H_W = 5;
    localparam int unsigned M_W = 6;
    localparam int unsigned S_W = 6;

    localparam logic [2:0] MODE_CLOCK  = 3'd0;
    localparam logic [2:0] MODE_SET_TH = 3'd1;
    localparam logic [2:0] MODE_SET_TM = 3'd2;
    localparam logic [2:0] MODE_SET_AH = 3'd3;
    localparam logic [2:0] MODE_SET_AM = 3'd4;

    typedef enum logic [2:0] {
        CLOCK  = MODE_CLOCK,
        SET_TH = MODE_SET_TH,
        SET_TM = MODE_SET_TM,
        SET_AH = MODE_SET_AH,
        SET_AM = MODE_SET_AM
    } state_e;

    // Field ring TH -> TM -> AH -> AM -> TH; CLOCK maps to itself.
    function automatic state_e next_field(input state_e s);
        case (s)
            SET_TH:  return SET_TM;
            SET_TM:  return SET_AH;
            SET_AH:  return SET_AM;
            SET_AM:  return SET_TH;
            default: return s;
        endcase
    endfunction

    function automatic state_e prev_field(input state_e s);
        case (s)
            SET_TH:  return SET_AM;
            SET_TM:  return SET_TH;
            SET_AH:  return SET_TM;
            SET_AM:  return SET_AH;
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/alarm_ring_timer.sv
// Loadable seconds down-counter; done pulses on the tick that takes the count from 1 to 0.
module alarm_ring_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (tick_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // A load or clear in the same cycle overrides the expiring tick.
    assign done_o = tick_i && !clear_i && !load_i && (cnt_q == W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock mode FSM, adjust enables, arm/ring/dismiss control.
// Optional snooze on btnD while ringing is enabled by defining ALARM_SNOOZE_EN.
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int unsigned RING_S   = 60,
    parameter int unsigned SNOOZE_S = 300
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_1hz,
    input  logic           btnC,
    input  logic           btnL,
    input  logic           btnR,
    input  logic           btnU,
    input  logic           btnD,
    input  logic [H_W-1:0] cur_h,
    input  logic [M_W-1:0] cur_m,
    input  logic [S_W-1:0] cur_s,
    input  logic [H_W-1:0] alm_h,
    input  logic [M_W-1:0] alm_m,
    output logic           adjust,
    output logic           ENS,
    output logic           ENTH,
    output logic           ENTM,
    output logic           ENAH,
    output logic           ENAM,
    output logic           up,
    output logic           down,
    output logic [2:0]     mode,
    output logic           show_alarm,
    output logic           alarm_led,
    output logic           buzzer
);

    localparam int unsigned RW = $clog2(RING_S + 1);

    state_e state_q;
    logic   armed_q, ringing_q, buzzer_q;
    logic   clock_st, any_btn, low_ok, enter_set, dismiss;
    logic   ring_start, ring_done, snz_done, rering;

    assign clock_st  = (state_q == CLOCK);
    assign any_btn   = btnC | btnL | btnR | btnU | btnD;
    assign low_ok    = ~btnC & ~btnR & ~btnL;
    assign enter_set = clock_st & btnC & ~ringing_q;
    assign dismiss   = ringing_q & any_btn;
    // btnC on the matching second wins: it enters setup, which never rings.
    assign ring_start = tick_1hz & clock_st & armed_q & ~ringing_q & ~btnC &
                        (cur_h == alm_h) & (cur_m == alm_m) & (cur_s == '0);
    assign rering     = ring_start | snz_done;

    alarm_ring_timer #(.W(RW)) u_ring (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_1hz),
        .load_i     (rering),
        .clear_i    (dismiss),
        .load_val_i (RW'(RING_S)),
        .done_o     (ring_done)
    );

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SW = $clog2(SNOOZE_S + 1);
    logic snooze_req;

    assign snooze_req = dismiss & btnD & ~btnC & ~btnR & ~btnL & ~btnU;

    alarm_ring_timer #(.W(SW)) u_snooze (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick_1hz),
        .load_i     (snooze_req),
        .clear_i    (enter_set | ring_start),
        .load_val_i (SW'(SNOOZE_S)),
        .done_o     (snz_done)
    );
`else
    logic unused_snooze;
    assign unused_snooze = (SNOOZE_S == 0);
    assign snz_done      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLOCK;
            armed_q   <= 1'b0;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
        end else if (ringing_q) begin
            // Any button is swallowed as a dismiss; mode and arm are untouched.
            if (dismiss || ring_done) begin
                ringing_q <= 1'b0;
                buzzer_q  <= 1'b0;
            end else if (tick_1hz) begin
                buzzer_q <= ~buzzer_q;
            end
        end else begin
            case (state_q)
                CLOCK: begin
                    if (btnC)
                        state_q <= SET_TH;
                    else if (btnU && low_ok)
                        armed_q <= ~armed_q;
                end
                default: begin
                    if (btnC)
                        state_q <= CLOCK;
                    else if (btnR)
                        state_q <= next_field(state_q);
                    else if (btnL)
                        state_q <= prev_field(state_q);
                end
            endcase
            if (rering) begin
                ringing_q <= 1'b1;
                buzzer_q  <= 1'b1;
            end
        end
    end

    assign mode       = state_q;
    assign adjust     = ~clock_st;
    assign ENS        = tick_1hz & clock_st;
    assign ENTH       = (state_q == SET_TH);
    assign ENTM       = (state_q == SET_TM);
    assign ENAH       = (state_q == SET_AH);
    assign ENAM       = (state_q == SET_AM);
    assign show_alarm = (state_q == SET_AH) | (state_q == SET_AM);
    assign up         = btnU & ~btnD & adjust & low_ok;
    assign down       = btnD & ~btnU & adjust & low_ok;
    assign alarm_led  = armed_q;
    assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Testbench for alarm_clock_ctrl: directed scenarios plus random traffic against a reference model.
`timescale 1ns/1ps
module tb_alarm_clock_ctrl;

    localparam int RING_S   = 60;
    localparam int SNOOZE_S = 300;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btnC = 1'b0, btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic [4:0] cur_h = 5'd0, alm_h = 5'd7;
    logic [5:0] cur_m = 6'd0, cur_s = 6'd1, alm_m = 6'd30;
    logic       adjust, ENS, ENTH, ENTM, ENAH, ENAM, up, down, show_alarm, alarm_led, buzzer;
    logic [2:0] mode;

    int total = 0;
    int bad   = 0;

    // Reference model: mode number, arm flag, ring with seconds left, snooze seconds left.
    int m_mode = 0, m_ring_left = 0, m_snz_left = 0;
    bit m_armed = 0, m_ring = 0, m_buzz = 0;

    alarm_clock_ctrl #(.RING_S(RING_S), .SNOOZE_S(SNOOZE_S)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btnC(btnC), .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
        .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s), .alm_h(alm_h), .alm_m(alm_m),
        .adjust(adjust), .ENS(ENS), .ENTH(ENTH), .ENTM(ENTM), .ENAH(ENAH), .ENAM(ENAM),
        .up(up), .down(down), .mode(mode), .show_alarm(show_alarm),
        .alarm_led(alarm_led), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : ref_model
        int nm, nrl, nsl;
        bit na, nr, nb, start;
        nm = m_mode; na = m_armed; nr = m_ring; nb = m_buzz;
        nrl = m_ring_left; nsl = m_snz_left; start = 0;
        if (rst) begin
            nm = 0; na = 0; nr = 0; nb = 0; nrl = 0; nsl = 0;
        end else if (m_ring) begin
            if (btnC || btnL || btnR || btnU || btnD) begin
                nr = 0; nb = 0; nrl = 0;
                if (SNZ && btnD && !btnC && !btnL && !btnR && !btnU) nsl = SNOOZE_S;
            end else if (tick_1hz) begin
                nrl = m_ring_left - 1;
                if (nrl == 0) begin nr = 0; nb = 0; end
                else nb = !m_buzz;
            end
        end else begin
            if (btnC) begin
                nm = (m_mode == 0) ? 1 : 0;
                nsl = 0;
            end else if (btnR) begin
                if (m_mode != 0) nm = m_mode % 4 + 1;
            end else if (btnL) begin
                if (m_mode != 0) nm = (m_mode + 2) % 4 + 1;
            end else if (btnU && m_mode == 0) begin
                na = !m_armed;
            end
            if (tick_1hz && m_mode == 0 && !btnC) begin
                if (m_armed && cur_h == alm_h && cur_m == alm_m && cur_s == 0) start = 1;
                else if (m_snz_left > 0) begin
                    nsl = m_snz_left - 1;
                    if (nsl == 0) start = 1;
                end
            end
            if (start) begin nr = 1; nb = 1; nrl = RING_S; nsl = 0; end
        end
        m_mode <= nm; m_armed <= na; m_ring <= nr; m_buzz <= nb;
        m_ring_left <= nrl; m_snz_left <= nsl;
    end

    function automatic logic [13:0] exp_out();
        bit adj, low;
        adj = (m_mode != 0);
        low = !btnC && !btnR && !btnL;
        return {3'(m_mode), adj, tick_1hz && m_mode == 0, m_mode == 1, m_mode == 2,
                m_mode == 3, m_mode == 4, btnU && !btnD && adj && low,
                btnD && !btnU && adj && low, m_mode >= 3, m_armed, m_buzz};
    endfunction

    task automatic press(input logic c, l, r, u, d, t);
        btnC = c; btnL = l; btnR = r; btnU = u; btnD = d; tick_1hz = t;
    endtask

    task automatic step();
        @(posedge clk); #1;
        {btnC, btnL, btnR, btnU, btnD, tick_1hz} = '0;
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin press(0, 0, 0, 0, 0, 1); step(); end
    endtask

    task automatic start_ring();
        cur_h = 5'd7; cur_m = 6'd30; cur_s = 6'd0;
        press(0, 0, 0, 0, 0, 1); step();
        cur_s = 6'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1; press(1, 0, 1, 1, 0, 1); step();
        total++; if (mode !== 3'd0) begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        total++; if (adjust !== 1'b0) begin bad++; $display("FAIL reset_adjust: got %b want 0", adjust); end
        total++; if (alarm_led !== 1'b0) begin bad++; $display("FAIL reset_led: got %b want 0", alarm_led); end
        total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
        total++; if ({ENTH, ENTM, ENAH, ENAM, show_alarm} !== 5'b0) begin
            bad++; $display("FAIL reset_enables: got %b want 00000", {ENTH, ENTM, ENAH, ENAM, show_alarm}); end
    endtask

    task automatic test_fsm_nav();
        int seq[4] = '{2, 3, 4, 1};
        press(1, 0, 0, 0, 0, 1); @(negedge clk);
        total++; if (ENS !== 1'b1) begin bad++; $display("FAIL nav_ens_clock: got %b want 1", ENS); end
        step();
        press(0, 0, 0, 0, 0, 1); @(negedge clk);
        total++; if ({mode, adjust, ENTH, ENS} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL nav_enter: got mode=%0d adj=%b enth=%b ens=%b want 1 1 1 0", mode, adjust, ENTH, ENS); end
        step();
        for (int i = 0; i < 4; i++) begin
            press(0, 0, 1, 0, 0, 0); step();
            total++; if (mode !== 3'(seq[i]) || show_alarm !== (seq[i] >= 3)) begin
                bad++; $display("FAIL nav_right%0d: got mode=%0d show=%b want %0d", i, mode, show_alarm, seq[i]); end
        end
        press(0, 1, 0, 0, 0, 0); step();
        total++; if (mode !== 3'd4 || ENAM !== 1'b1) begin bad++; $display("FAIL nav_left: got mode=%0d enam=%b want 4 1", mode, ENAM); end
        press(1, 1, 1, 0, 0, 0); step();
        total++; if (mode !== 3'd0 || adjust !== 1'b0) begin bad++; $display("FAIL nav_exit: got mode=%0d adj=%b want 0 0", mode, adjust); end
    endtask

    task automatic test_updown();
        press(1, 0, 0, 0, 0, 0); step();
        press(0, 0, 1, 0, 0, 0); step();
        total++; if (mode !== 3'd2 || ENTM !== 1'b1) begin bad++; $display("FAIL ud_tm: got mode=%0d entm=%b want 2 1", mode, ENTM); end
        press(0, 0, 0, 1, 1, 0); @(negedge clk);
        total++; if ({up, down} !== 2'b00) begin bad++; $display("FAIL ud_both: got %b want 00", {up, down}); end
        step();
        press(0, 0, 0, 1, 0, 0); @(negedge clk);
        total++; if ({up, down} !== 2'b10) begin bad++; $display("FAIL ud_up: got %b want 10", {up, down}); end
        step(); @(negedge clk);
        total++; if ({up, down} !== 2'b00) begin bad++; $display("FAIL ud_up_release: got %b want 00", {up, down}); end
        press(0, 0, 0, 0, 1, 0); @(negedge clk);
        total++; if ({up, down} !== 2'b01) begin bad++; $display("FAIL ud_down: got %b want 01", {up, down}); end
        step();
        press(0, 0, 1, 1, 0, 0); @(negedge clk);
        total++; if (up !== 1'b0) begin bad++; $display("FAIL ud_prio: got up=%b want 0", up); end
        step();
        total++; if (mode !== 3'd3) begin bad++; $display("FAIL ud_prio_mode: got %0d want 3", mode); end
        press(1, 0, 0, 0, 0, 0); step();
    endtask

    task automatic test_ring();
        bit exp;
        press(0, 0, 0, 1, 0, 0); @(negedge clk);
        total++; if (up !== 1'b0) begin bad++; $display("FAIL ring_up_clock: got %b want 0", up); end
        step();
        total++; if (alarm_led !== 1'b1) begin bad++; $display("FAIL ring_arm: got %b want 1", alarm_led); end
        start_ring();
        total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL ring_start: got %b want 1", buzzer); end
        for (int k = 1; k <= RING_S + 2; k++) begin
            ticks(1);
            exp = (k < RING_S) ? (k % 2 == 0) : 1'b0;
            total++; if (buzzer !== exp) begin bad++; $display("FAIL ring_tick%0d: got %b want %b", k, buzzer, exp); end
        end
        total++; if (mode !== 3'd0 || alarm_led !== 1'b1) begin
            bad++; $display("FAIL ring_after: got mode=%0d led=%b want 0 1", mode, alarm_led); end
    endtask

    task automatic test_dismiss();
        start_ring(); ticks(1);
        press(0, 0, 1, 0, 0, 1); step();
        total++; if ({buzzer, mode, alarm_led} !== {1'b0, 3'd0, 1'b1}) begin
            bad++; $display("FAIL dis_btnr: got buz=%b mode=%0d led=%b want 0 0 1", buzzer, mode, alarm_led); end
        ticks(3);
        total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL dis_quiet: got %b want 0", buzzer); end
        start_ring(); press(0, 0, 0, 1, 0, 0); step();
        total++; if (alarm_led !== 1'b1 || buzzer !== 1'b0) begin
            bad++; $display("FAIL dis_btnu: got led=%b buz=%b want 1 0", alarm_led, buzzer); end
        start_ring(); press(1, 0, 0, 0, 0, 0); step();
        total++; if (mode !== 3'd0 || buzzer !== 1'b0) begin
            bad++; $display("FAIL dis_btnc: got mode=%0d buz=%b want 0 0", mode, buzzer); end
    endtask

    task automatic test_btnd();
        start_ring(); press(0, 0, 0, 0, 1, 0); step();
        total++; if (buzzer !== 1'b0 || mode !== 3'd0) begin bad++; $display("FAIL btnd_stop: got buz=%b mode=%0d want 0 0", buzzer, mode); end
        if (SNZ) begin
            ticks(SNOOZE_S - 1);
            total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL snz_quiet: got %b want 0", buzzer); end
            ticks(1);
            total++; if (buzzer !== 1'b1) begin bad++; $display("FAIL snz_rering: got %b want 1", buzzer); end
            ticks(1);
            total++; if (buzzer !== 1'b0) begin bad++; $display("FAIL snz_toggle: got %b want 0", buzzer); end
            press(1, 0, 0, 0, 0, 0); step();
            total++; if (buzzer !== 1'b0 || mode !== 3'd0) begin bad++; $display("FAIL snz_dismiss: got buz=%b mode=%0d want 0 0", buzzer, mode); end
            start_ring(); press(0, 0, 0, 0, 1, 0); step(); ticks(100);
            rst = 1'b1; press(0, 0, 0, 0, 0, 1); step();
            ticks(SNOOZE_S);
            total++; if (buzzer !== 1'b0 || alarm_led !== 1'b0) begin
                bad++; $display("FAIL snz_rst: got buz=%b led=%b want 0 0", buzzer, alarm_led); end
        end else begin
            ticks(SNOOZE_S + 50);
            total++; if (buzzer !== 1'b0 || alarm_led !== 1'b1) begin
                bad++; $display("FAIL btnd_dismiss: got buz=%b led=%b want 0 1", buzzer, alarm_led); end
            start_ring(); ticks(3);
            rst = 1'b1; press(1, 0, 0, 1, 0, 1); step();
            total++; if ({mode, buzzer, alarm_led} !== {3'd0, 1'b0, 1'b0}) begin
                bad++; $display("FAIL ring_rst: got mode=%0d buz=%b led=%b want 0 0 0", mode, buzzer, alarm_led); end
        end
    endtask

    task automatic test_random();
        logic [13:0] obs, exp;
        int errs = 0;
        rst = 1'b1; step();
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            tick_1hz = $urandom_range(0, 1);
            btnC     = ($urandom_range(0, 15) == 0);
            btnL     = ($urandom_range(0, 15) == 0);
            btnR     = ($urandom_range(0, 15) == 0);
            btnU     = ($urandom_range(0, 11) == 0);
            btnD     = ($urandom_range(0, 15) == 0);
            cur_h    = ($urandom_range(0, 3) != 0) ? alm_h : 5'($urandom_range(0, 23));
            cur_m    = ($urandom_range(0, 3) != 0) ? alm_m : 6'($urandom_range(0, 59));
            cur_s    = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 59));
            @(negedge clk);
            obs = {mode, adjust, ENS, ENTH, ENTM, ENAH, ENAM, up, down, show_alarm, alarm_led, buzzer};
            exp = exp_out();
            total++;
            if (obs !== exp) begin
                bad++;
                if (errs < 10) $display("FAIL rand_cycle%0d: got %h want %h", i, obs, exp);
                errs++;
            end
            @(posedge clk); #1;
        end
        {btnC, btnL, btnR, btnU, btnD, tick_1hz, rst} = '0;
    endtask

    initial begin
        #1;
        test_reset();
        test_fsm_nav();
        test_updown();
        test_ring();
        test_dismiss();
        test_btnd();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
